// File: rtl/markov_first_build_pkg.sv
// Shared definitions for the first-order Markov list builder and its merge-stage consumer.
// Latency: n/a (types and constants). Backpressure: n/a.
// Holds default widths, the {prev,next,count} entry layout and the 3-bit FSM encoding.
package markov_first_build_pkg;

    localparam int NOTE_W_DEF      = 7;
    localparam int COUNT_W_DEF     = 8;
    localparam int MAX_ENTRIES_DEF = 64;
    localparam int ADDR_W_DEF      = 6;
    localparam int ENTRY_W_DEF     = 2 * NOTE_W_DEF + COUNT_W_DEF;

    typedef struct packed {
        logic [NOTE_W_DEF-1:0]  prev;
        logic [NOTE_W_DEF-1:0]  next;
        logic [COUNT_W_DEF-1:0] count;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_NOTE = 3'd1,
        SEARCH    = 3'd2,
        INCREMENT = 3'd3,
        APPEND    = 3'd4,
        FINISH    = 3'd5
    } state_t;

endpackage

// File: rtl/markov_entry_ram.sv
// Transition-list storage: register array, one synchronous write, two combinational reads.
// Latency: write visible the cycle after we; reads are same-cycle.
// Backpressure: none; contents are never cleared so stale entries survive reset.
module markov_entry_ram #(
    parameter int WIDTH  = 22,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/markov_first_build.sv
// Builds the {prev,next,count} transition list from a streamed note sequence, one build per start.
// Latency: per pair up to entry_count search cycles + 1 update + 1 return to WAIT_NOTE.
// Backpressure: note_ready is high only in WAIT_NOTE, so notes stall while a pair is being placed.
module markov_first_build
    import markov_first_build_pkg::*;
#(
    parameter int NOTE_W      = NOTE_W_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int MAX_ENTRIES = MAX_ENTRIES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               note_valid,
    input  logic [NOTE_W-1:0]  note_data,
    input  logic               note_last,
    output logic               note_ready,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [NOTE_W-1:0]  rd_prev,
    output logic [NOTE_W-1:0]  rd_next,
    output logic [COUNT_W-1:0] rd_count,
    output logic [ADDR_W:0]    entry_count,
    output logic               overflow,
    output logic               done
);

    localparam int ENTRY_W = 2 * NOTE_W + COUNT_W;

    state_t              state, state_nx;
    logic                has_prev, last_seen, overflow_q;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W-1:0]   idx;
    logic [NOTE_W-1:0]   prev_q, pair_prev, pair_next;
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [ENTRY_W-1:0]  wdata, srch_dat, ext_dat;
    logic [COUNT_W-1:0]  srch_count;
    logic                xfer, clear, match, last_idx, full;

    markov_entry_ram #(.WIDTH(ENTRY_W), .DEPTH(MAX_ENTRIES), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (idx),
        .rdata_a (srch_dat),
        .raddr_b (rd_addr),
        .rdata_b (ext_dat)
    );

    assign srch_count = srch_dat[COUNT_W-1:0];
    assign match      = (srch_dat[ENTRY_W-1 -: NOTE_W] == pair_prev) &&
                        (srch_dat[COUNT_W +: NOTE_W] == pair_next);
    assign last_idx   = ({1'b0, idx} == (cnt_q - (ADDR_W+1)'(1)));
    assign full       = (cnt_q == (ADDR_W+1)'(MAX_ENTRIES));
    assign xfer       = note_valid && note_ready;
    assign clear      = start && ((state == IDLE) || (state == FINISH));

    assign rd_prev     = ext_dat[ENTRY_W-1 -: NOTE_W];
    assign rd_next     = ext_dat[COUNT_W +: NOTE_W];
    assign rd_count    = ext_dat[COUNT_W-1:0];
    assign entry_count = cnt_q;
    assign overflow    = overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        note_ready = 1'b0;
        done       = 1'b0;
        we         = 1'b0;
        waddr      = idx;
        wdata      = {pair_prev, pair_next, COUNT_W'(1)};
        case (state)
            IDLE: begin
                if (start) state_nx = WAIT_NOTE;
            end
            WAIT_NOTE: begin
                note_ready = 1'b1;
                if (xfer) begin
                    if (!has_prev)        state_nx = note_last ? FINISH : WAIT_NOTE;
                    else if (cnt_q == '0) state_nx = APPEND;
                    else                  state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (match)         state_nx = INCREMENT;
                else if (last_idx) state_nx = APPEND;
            end
            INCREMENT: begin
                we       = 1'b1;
                wdata    = {pair_prev, pair_next,
                            (&srch_count) ? srch_count : srch_count + COUNT_W'(1)};
                state_nx = last_seen ? FINISH : WAIT_NOTE;
            end
            APPEND: begin
                we       = !full;
                waddr    = cnt_q[ADDR_W-1:0];
                state_nx = last_seen ? FINISH : WAIT_NOTE;
            end
            FINISH: begin
                done = 1'b1;
                if (start) state_nx = WAIT_NOTE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_prev   <= 1'b0;
            last_seen  <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            idx        <= '0;
            prev_q     <= '0;
            pair_prev  <= '0;
            pair_next  <= '0;
        end else if (clear) begin
            has_prev   <= 1'b0;
            last_seen  <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else if (xfer) begin
            last_seen <= note_last;
            prev_q    <= note_data;
            if (!has_prev) begin
                has_prev <= 1'b1;
            end else begin
                pair_prev <= prev_q;
                pair_next <= note_data;
                idx       <= '0;
            end
        end else if (state == SEARCH) begin
            if (!match && !last_idx) idx <= idx + ADDR_W'(1);
        end else if (state == APPEND) begin
            // A full list keeps its contents; the dropped pair is only flagged.
            if (full) overflow_q <= 1'b1;
            else      cnt_q      <= cnt_q + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_markov_first_build.sv
// Randomised and directed bench for markov_first_build against a list-of-pairs model.
module tb_markov_first_build;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       note_valid = 1'b0;
    logic [6:0] note_data = '0;
    logic       note_last = 1'b0;
    logic       note_ready;
    logic [5:0] rd_addr = '0;
    logic [6:0] rd_prev, rd_next;
    logic [7:0] rd_count;
    logic [6:0] entry_count;
    logic       overflow, done;

    markov_first_build dut (
        .clk(clk), .reset(reset), .start(start),
        .note_valid(note_valid), .note_data(note_data), .note_last(note_last),
        .note_ready(note_ready), .rd_addr(rd_addr),
        .rd_prev(rd_prev), .rd_next(rd_next), .rd_count(rd_count),
        .entry_count(entry_count), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: ordered list of distinct pairs with saturating counts.
    int m_prev [64];
    int m_next [64];
    int m_cnt  [64];
    int m_n    = 0;
    bit m_ovf  = 0;
    bit m_has  = 0;
    int m_last = 0;
    int seq [$];

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic model_clear();
        m_n = 0; m_ovf = 0; m_has = 0;
    endtask

    task automatic model_note(input int n);
        int hit;
        if (!m_has) begin
            m_has = 1;
        end else begin
            hit = -1;
            for (int i = 0; i < m_n; i++)
                if (hit < 0 && m_prev[i] == m_last && m_next[i] == n) hit = i;
            if (hit >= 0) begin
                if (m_cnt[hit] < 255) m_cnt[hit]++;
            end else if (m_n < 64) begin
                m_prev[m_n] = m_last; m_next[m_n] = n; m_cnt[m_n] = 1; m_n++;
            end else begin
                m_ovf = 1;
            end
        end
        m_last = n;
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            check("entry_count", entry_count, m_n);
            check("overflow", overflow, m_ovf);
            check("ready_in_finish", note_ready, 0);
            if (rd_addr < m_n) begin
                check("rd_prev", rd_prev, m_prev[rd_addr]);
                check("rd_next", rd_next, m_next[rd_addr]);
                check("rd_count", rd_count, m_cnt[rd_addr]);
            end
        end
    end

    // All driver tasks are entered and left at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        @(negedge clk);
        check("done_after_start", done, 0);
    endtask

    task automatic send_note(input int n, input bit last);
        int w;
        if ($urandom_range(0, 3) == 0) begin
            note_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        note_data  = 7'(n);
        note_last  = last;
        note_valid = 1'b1;
        w = 0;
        while (!note_ready && w < 300) begin @(negedge clk); w++; end
        if (!note_ready) begin
            check("ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
            model_note(n);
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        check("done_seen", done, 1);
    endtask

    task automatic sweep();
        for (int i = 0; i < m_n; i++) begin
            @(posedge clk); #1 rd_addr = 6'(i);
            @(negedge clk);
        end
    endtask

    task automatic run_seq();
        pulse_start();
        for (int i = 0; i < seq.size(); i++) send_note(seq[i], i == seq.size() - 1);
        wait_done();
        sweep();
    endtask

    task automatic read_lit(input int a, input int p, input int n, input int c);
        @(posedge clk); #1 rd_addr = 6'(a); #1;
        check("lit_prev", rd_prev, p);
        check("lit_next", rd_next, n);
        check("lit_count", rd_count, c);
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_done", done, 0);
        check("rst_count", entry_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ready", note_ready, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        seq = '{3, 5, 3, 5};
        run_seq();
        check("t1_count", entry_count, 2);
        read_lit(0, 3, 5, 2);
        read_lit(1, 5, 3, 1);

        seq = '{9};
        run_seq();
        check("single_count", entry_count, 0);
        check("single_done", done, 1);
        read_lit(0, 3, 5, 2);

        seq = '{4, 4, 4};
        run_seq();
        check("self_count", entry_count, 1);
        read_lit(0, 4, 4, 2);

        seq = {};
        for (int i = 0; i < 66; i++) seq.push_back(10 + i);
        run_seq();
        check("ovf_count", entry_count, 64);
        check("ovf_flag", overflow, 1);
        read_lit(63, 73, 74, 1);

        seq = {};
        for (int i = 0; i < 600; i++) seq.push_back((i % 2 == 0) ? 1 : 2);
        run_seq();
        read_lit(0, 1, 2, 255);
        read_lit(1, 2, 1, 255);

        for (int r = 0; r < 6; r++) begin
            seq = {};
            for (int i = 0, len = $urandom_range(1, 40); i < len; i++)
                seq.push_back($urandom_range(0, 7));
            run_seq();
        end

        pulse_start();
        for (int i = 0; i < 10; i++) send_note(i, 1'b0);
        send_note(20, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_count", entry_count, 0);
        check("abort_ready", note_ready, 0);
        check("abort_ovf", overflow, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        note_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", note_ready, 0);

        seq = '{3, 5, 3, 5};
        run_seq();
        check("rebuild_count", entry_count, 2);
        read_lit(0, 3, 5, 2);
        read_lit(1, 5, 3, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
